nios_dbg_oci_access_arbiter: RTL and testbench



---
 rtl/nios_dbg_oci_access_arbiter_if.sv | 44 ++++
 rtl/nios_dbg_oci_access_arbiter.sv | 131 +++++++++++++
 tb/tb_nios_dbg_oci_access_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/nios_dbg_oci_access_arbiter_if.sv
// Requester, response and OCI-side signals of the debug access arbiter.
// The arbiter uses the slave modport; the environment drives through master.
interface nios_dbg_oci_access_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              r0_valid;
  logic              r0_ready;
  logic              r0_write;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_rvalid;
  logic              r1_valid;
  logic              r1_ready;
  logic              r1_write;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              m_cmd;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_done;
  logic [DATA_W-1:0] m_rdata;
  logic              busy;

  modport slave (
    input  r0_valid, r0_write, r0_addr, r0_wdata,
    input  r1_valid, r1_write, r1_addr, r1_wdata,
    input  m_done, m_rdata,
    output r0_ready, r0_rvalid, r1_ready, r1_rvalid,
    output r_rdata, r_err, m_cmd, m_write, m_addr, m_wdata, busy
  );

  modport master (
    output r0_valid, r0_write, r0_addr, r0_wdata,
    output r1_valid, r1_write, r1_addr, r1_wdata,
    output m_done, m_rdata,
    input  r0_ready, r0_rvalid, r1_ready, r1_rvalid,
    input  r_rdata, r_err, m_cmd, m_write, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/nios_dbg_oci_access_arbiter.sv
// Round-robin, single-outstanding arbiter of two requesters onto the OCI debug resource.
// Accept-to-response >= 3 cycles (timeout aborts WAIT); rN_ready only in IDLE, one command per >= 4 cycles.
module nios_dbg_oci_access_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  nios_dbg_oci_access_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              pri_q, pri_d;
  logic              gid_q, gid_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              m_cmd_q, m_cmd_d;
  logic              m_write_q, m_write_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] r_rdata_q, r_rdata_d;
  logic              r_err_q, r_err_d;
  logic              r0_rvalid_q, r0_rvalid_d;
  logic              r1_rvalid_q, r1_rvalid_d;
  logic              busy_q, busy_d;
  logic              sel0, sel1, idle;

  // A lone valid requester always wins; pri only breaks ties.
  assign sel0 = bus.r0_valid & (~bus.r1_valid | ~pri_q);
  assign sel1 = bus.r1_valid & (~bus.r0_valid | pri_q);
  assign idle = (state_q == IDLE);

  assign bus.r0_ready  = idle & sel0;
  assign bus.r1_ready  = idle & sel1;
  assign bus.r0_rvalid = r0_rvalid_q;
  assign bus.r1_rvalid = r1_rvalid_q;
  assign bus.r_rdata   = r_rdata_q;
  assign bus.r_err     = r_err_q;
  assign bus.m_cmd     = m_cmd_q;
  assign bus.m_write   = m_write_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.busy      = busy_q;

  always_comb begin
    state_d   = state_q;
    pri_d     = pri_q;
    gid_d     = gid_q;
    cnt_d     = cnt_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    r_rdata_d = r_rdata_q;
    r_err_d   = r_err_q;
    case (state_q)
      IDLE: begin
        if (sel0 | sel1) begin
          state_d   = ISSUE;
          gid_d     = sel1;
          m_write_d = sel1 ? bus.r1_write : bus.r0_write;
          m_addr_d  = sel1 ? bus.r1_addr  : bus.r0_addr;
          m_wdata_d = sel1 ? bus.r1_wdata : bus.r0_wdata;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Completion takes precedence over a timeout in the same cycle.
        if (bus.m_done) begin
          r_rdata_d = bus.m_rdata;
          r_err_d   = 1'b0;
          state_d   = RESP;
        end else if (cnt_q == CNT_LAST) begin
          r_rdata_d = '0;
          r_err_d   = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        pri_d   = ~gid_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Strobes are registered: decode them from the state being entered.
    m_cmd_d     = (state_d == ISSUE);
    r0_rvalid_d = (state_d == RESP) & ~gid_d;
    r1_rvalid_d = (state_d == RESP) & gid_d;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pri_q       <= 1'b0;
      gid_q       <= 1'b0;
      cnt_q       <= '0;
      m_cmd_q     <= 1'b0;
      m_write_q   <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      r_rdata_q   <= '0;
      r_err_q     <= 1'b0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pri_q       <= pri_d;
      gid_q       <= gid_d;
      cnt_q       <= cnt_d;
      m_cmd_q     <= m_cmd_d;
      m_write_q   <= m_write_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      r_rdata_q   <= r_rdata_d;
      r_err_q     <= r_err_d;
      r0_rvalid_q <= r0_rvalid_d;
      r1_rvalid_q <= r1_rvalid_d;
      busy_q      <= busy_d;
    end
  end
endmodule

// File: tb/tb_nios_dbg_oci_access_arbiter.sv
// Directed bench for the OCI access arbiter, built with TIMEOUT = 4.
// Inputs change and outputs are sampled on the falling edge.
module tb_nios_dbg_oci_access_arbiter;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  nios_dbg_oci_access_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  nios_dbg_oci_access_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0, v1, wr;
    logic [7:0]  a0, a1;
    logic [31:0] wd;
    int          dly;     // m_done offset from the first WAIT cycle; >= 4 means never
    logic        di;      // also pulse m_done during ISSUE
    logic [31:0] rd;
    logic        gid;
    int          lat;     // cycles from transfer to rvalid
    logic        err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.r0_valid = 0; bus.r0_write = 0; bus.r0_addr = 0; bus.r0_wdata = 0;
    bus.r1_valid = 0; bus.r1_write = 0; bus.r1_addr = 0; bus.r1_wdata = 0;
    bus.m_done = 0;   bus.m_rdata = 0;
  endtask

  task automatic run_txn(input vec_t v);
    bit          got;
    logic        g;
    int          lat;
    int          ncmd;
    logic [7:0]  ea;
    logic [31:0] ew;
    @(negedge clk);
    bus.r0_valid = v.v0; bus.r1_valid = v.v1;
    bus.r0_write = v.wr; bus.r1_write = v.wr;
    bus.r0_addr  = v.a0; bus.r1_addr  = v.a1;
    bus.r0_wdata = v.wd; bus.r1_wdata = ~v.wd;
    got = 0; g = 0;
    for (int t = 0; t < 6 && !got; t++) begin
      #1;
      if (bus.r0_ready || bus.r1_ready) begin
        got = 1;
        g   = bus.r1_ready;
      end else begin
        @(negedge clk);
      end
    end
    chk("grant_seen", got, 1);
    chk("grant_id", g, v.gid);
    ea = v.gid ? v.a1 : v.a0;
    ew = v.gid ? ~v.wd : v.wd;
    @(negedge clk);
    bus.r0_valid = 0; bus.r1_valid = 0;
    chk("m_cmd_issue", bus.m_cmd, 1);
    chk("m_addr", bus.m_addr, ea);
    chk("m_write", bus.m_write, v.wr);
    chk("m_wdata", bus.m_wdata, ew);
    chk("busy_issue", bus.busy, 1);
    bus.m_done  = v.di;
    bus.m_rdata = 32'hDEADBEEF;
    got = 0; lat = 0; ncmd = 0;
    for (int c = 2; c < 12 && !got; c++) begin
      @(negedge clk);
      // Requester fields wander while busy; the latched command must not follow.
      bus.r0_addr = bus.r0_addr + 8'd1;
      bus.r1_addr = ~bus.r1_addr;
      if (bus.m_cmd) ncmd++;
      if (bus.r0_rvalid || bus.r1_rvalid) begin
        got = 1;
        lat = c;
        chk("r0_rvalid", bus.r0_rvalid, !v.gid);
        chk("r1_rvalid", bus.r1_rvalid, v.gid);
        chk("r_err", bus.r_err, v.err);
        chk("r_rdata", bus.r_rdata, v.exp_rd);
        chk("m_addr_hold", bus.m_addr, ea);
      end
      bus.m_done  = (!got && (c - 2) == v.dly);
      bus.m_rdata = bus.m_done ? v.rd : 32'hDEADBEEF;
    end
    bus.m_done = 0;
    chk("rvalid_seen", got, 1);
    chk("latency", lat, v.lat);
    chk("extra_m_cmd", ncmd, 0);
    @(negedge clk);
    chk("busy_after", bus.busy, 0);
    chk("rvalid_after", {bus.r0_rvalid, bus.r1_rvalid}, 0);
  endtask

  // After a timeout: late completions in IDLE must be invisible.
  task automatic late_done_check();
    for (int k = 0; k < 3; k++) begin
      bus.m_done  = 1;
      bus.m_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      chk("late_rvalid", {bus.r0_rvalid, bus.r1_rvalid}, 0);
      chk("late_busy", bus.busy, 0);
      chk("late_m_cmd", bus.m_cmd, 0);
    end
    bus.m_done = 0;
    chk("late_r_err_hold", bus.r_err, 1);
    chk("late_r_rdata_hold", bus.r_rdata, 0);
  endtask

  task automatic reset_mid_wait();
    @(negedge clk);
    bus.r1_valid = 1; bus.r1_write = 1; bus.r1_addr = 8'h70; bus.r1_wdata = 32'h0BADF00D;
    #1;
    chk("rst_pre_ready", bus.r1_ready, 1);
    @(negedge clk);
    bus.r1_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_busy", bus.busy, 1);
    reset = 1;
    #1;
    chk("rst_async_busy", bus.busy, 0);
    chk("rst_async_m_addr", bus.m_addr, 0);
    chk("rst_async_m_write", bus.m_write, 0);
    chk("rst_async_m_wdata", bus.m_wdata, 0);
    chk("rst_async_r_rdata", bus.r_rdata, 0);
    chk("rst_async_r_err", bus.r_err, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    for (int k = 0; k < 6; k++) begin
      bus.m_done = (k == 1);
      @(negedge clk);
      chk("rst_no_rvalid", {bus.r0_rvalid, bus.r1_rvalid}, 0);
      chk("rst_idle_busy", bus.busy, 0);
    end
    bus.m_done = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //           v0 v1 wr a0     a1     wd            dly di rd            gid lat err exp_rd
    tbl[0]  = '{1, 0, 0, 8'h12, 8'h00, 32'h0,        1,  0, 32'hCAFEF00D, 0,  4,  0, 32'hCAFEF00D};
    tbl[1]  = '{1, 1, 0, 8'h20, 8'h21, 32'h0,        0,  0, 32'h11111111, 1,  3,  0, 32'h11111111};
    tbl[2]  = '{1, 1, 1, 8'h22, 8'h23, 32'hAAAA0001, 0,  0, 32'h22222222, 0,  3,  0, 32'h22222222};
    tbl[3]  = '{1, 1, 0, 8'h24, 8'h25, 32'h0,        0,  0, 32'h33333333, 1,  3,  0, 32'h33333333};
    tbl[4]  = '{0, 1, 1, 8'h00, 8'h05, 32'hFFFFFFFE, 99, 1, 32'h44444444, 1,  6,  1, 32'h0};
    tbl[5]  = '{1, 0, 0, 8'h33, 8'h00, 32'h0,        3,  0, 32'hA5A5A5A5, 0,  6,  0, 32'hA5A5A5A5};
    tbl[6]  = '{1, 0, 0, 8'h40, 8'h00, 32'h0,        2,  0, 32'h55555555, 0,  5,  0, 32'h55555555};
    tbl[7]  = '{1, 1, 1, 8'h41, 8'h42, 32'h12345678, 0,  0, 32'h66666666, 1,  3,  0, 32'h66666666};
    tbl[8]  = '{1, 0, 0, 8'h50, 8'h00, 32'h0,        0,  0, 32'h77777777, 0,  3,  0, 32'h77777777};
    tbl[9]  = '{1, 1, 0, 8'h60, 8'h61, 32'h0,        1,  0, 32'h88888888, 0,  4,  0, 32'h88888888};
    tbl[10] = '{0, 1, 1, 8'h00, 8'h62, 32'h35014541, 0,  0, 32'h99999999, 1,  3,  0, 32'h99999999};

    reset = 1;
    clear_inputs();
    repeat (2) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_m_cmd", bus.m_cmd, 0);
    chk("reset_m_addr", bus.m_addr, 0);
    chk("reset_m_wdata", bus.m_wdata, 0);
    chk("reset_r_rdata", bus.r_rdata, 0);
    chk("reset_rvalid", {bus.r0_rvalid, bus.r1_rvalid, bus.r_err, bus.m_write}, 0);
    reset = 0;

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i]);
      if (tbl[i].err) late_done_check();
    end
    reset_mid_wait();
    for (int i = 9; i < 11; i++) run_txn(tbl[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
